// File: rtl/etherneco_syncgpio_slave_ex.sv
// etherneco_syncgpio_slave_ex: inline sync-GPIO slave that captures global/own-slot payload bytes
// and overwrites masked bits with outgoing GPIO values through a one-stage valid/ready register.
module etherneco_syncgpio_slave_ex #(
  parameter int          GLOBAL_BYTES = 4,
  parameter int          LOCAL_BYTES  = 4,
  parameter int          LOCAL_OFFSET = 0,
  parameter int          MAX_NODES    = 16,
  parameter logic [7:0]  PACKET_TYPE  = 8'h10,
  parameter int          COUNT_BITS   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                node_id,
  input  logic [GLOBAL_BYTES*8-1:0] global_tx_mask,
  input  logic [GLOBAL_BYTES*8-1:0] global_tx_data,
  input  logic [LOCAL_BYTES*8-1:0]  local_tx_mask,
  input  logic [LOCAL_BYTES*8-1:0]  local_tx_data,
  output logic [GLOBAL_BYTES*8-1:0] global_rx_data,
  output logic [LOCAL_BYTES*8-1:0]  local_rx_data,
  output logic                      rx_valid,
  output logic                      rx_drop,
  input  logic                      rx_start,
  input  logic                      rx_end,
  input  logic                      rx_error,
  input  logic [7:0]                rx_type,
  input  logic [7:0]                rx_node,
  input  logic                      s_packet_payload,
  input  logic                      s_packet_fcs,
  input  logic                      s_packet_crc_en,
  input  logic                      s_packet_crc_first,
  input  logic                      s_packet_first,
  input  logic                      s_packet_last,
  input  logic [7:0]                s_packet_data,
  input  logic                      s_packet_valid,
  output logic                      s_packet_ready,
  output logic                      m_packet_payload,
  output logic                      m_packet_fcs,
  output logic                      m_packet_crc_en,
  output logic                      m_packet_crc_first,
  output logic                      m_packet_first,
  output logic                      m_packet_last,
  output logic [7:0]                m_packet_data,
  output logic                      m_packet_valid,
  input  logic                      m_packet_ready
);
  localparam int GW = GLOBAL_BYTES * 8;
  localparam int LW = LOCAL_BYTES * 8;
  localparam int CW = COUNT_BITS + 8;
  typedef enum logic [1:0] {IDLE, ACTIVE, BYPASS} state_t;
  state_t state_q, state_d;
  logic [COUNT_BITS-1:0] cnt_q, cnt_d;
  logic [GW-1:0] g_mask_q, g_mask_d, g_data_q, g_data_d, g_stage_q, g_stage_d, g_rx_q, g_rx_d;
  logic [LW-1:0] l_mask_q, l_mask_d, l_data_q, l_data_d, l_stage_q, l_stage_d, l_rx_q, l_rx_d;
  logic rx_valid_q, rx_valid_d, rx_drop_q, rx_drop_d, m_valid_q, m_valid_d;
  logic [13:0] m_q, m_d;
  logic accept, pay_acc, fresh, loc_en, active, end_ok, commit, drop, modify;
  logic [CW-1:0] cnt_w, base;
  logic [7:0] mb, db;
  logic unused_rx_node;
  assign unused_rx_node = ^rx_node;
  assign s_packet_ready = !m_valid_q || m_packet_ready;
  assign accept = s_packet_valid && s_packet_ready;
  assign pay_acc = accept && s_packet_payload;
  assign fresh = cnt_q == '0;
  assign cnt_w = CW'(cnt_q);
  assign base = CW'(GLOBAL_BYTES + LOCAL_OFFSET) + CW'(node_id) * CW'(LOCAL_BYTES);
  assign loc_en = int'(node_id) < MAX_NODES;
  assign {m_packet_payload, m_packet_fcs, m_packet_crc_en, m_packet_crc_first,
          m_packet_first, m_packet_last, m_packet_data} = m_q;
  assign m_packet_valid = m_valid_q;
  assign global_rx_data = g_rx_q;
  assign local_rx_data = l_rx_q;
  assign rx_valid = rx_valid_q;
  assign rx_drop = rx_drop_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  // A restart on rx_start wins over rx_end; the old packet's verdict is taken from state_q.
  always_comb state_d = rx_start ? (rx_type == PACKET_TYPE ? ACTIVE : BYPASS) :
                        rx_end ? IDLE : state_q;
  always_comb begin
    active = state_q == ACTIVE;
    end_ok = cnt_w >= CW'(GLOBAL_BYTES) && (!loc_en || cnt_w >= base + CW'(LOCAL_BYTES));
    commit = rx_end && active && !rx_error && end_ok;
    drop = rx_end && active && !commit;
  end
  always_comb begin
    g_mask_d = fresh && pay_acc ? global_tx_mask : g_mask_q;
    g_data_d = fresh && pay_acc ? global_tx_data : g_data_q;
    l_mask_d = fresh && pay_acc ? local_tx_mask : l_mask_q;
    l_data_d = fresh && pay_acc ? local_tx_data : l_data_q;
    mb = '0;
    db = '0;
    g_stage_d = g_stage_q;
    l_stage_d = l_stage_q;
    for (int i = 0; i < LOCAL_BYTES; i++)
      if (loc_en && cnt_w >= CW'(GLOBAL_BYTES) && cnt_w == base + CW'(i)) begin
        mb = l_mask_d[8*i+:8];
        db = l_data_d[8*i+:8];
        l_stage_d[8*i+:8] = pay_acc ? s_packet_data : l_stage_q[8*i+:8];
      end
    // Global loop runs last so it overrides any overlapping local slot.
    for (int i = 0; i < GLOBAL_BYTES; i++)
      if (cnt_w == CW'(i)) begin
        mb = g_mask_d[8*i+:8];
        db = g_data_d[8*i+:8];
        g_stage_d[8*i+:8] = pay_acc ? s_packet_data : g_stage_q[8*i+:8];
      end
    modify = active && s_packet_payload && !s_packet_fcs;
    cnt_d = rx_start ? '0 : pay_acc && !(&cnt_q) ? cnt_q + COUNT_BITS'(1) : cnt_q;
    m_valid_d = accept ? 1'b1 : m_packet_ready ? 1'b0 : m_valid_q;
    m_d = accept ? {s_packet_payload, s_packet_fcs, s_packet_crc_en, s_packet_crc_first,
                    s_packet_first, s_packet_last,
                    modify ? (s_packet_data & ~mb) | (db & mb) : s_packet_data} : m_q;
    g_rx_d = commit ? g_stage_q : g_rx_q;
    l_rx_d = commit && loc_en ? l_stage_q : l_rx_q;
    rx_valid_d = commit;
    rx_drop_d = drop;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt_q <= '0;
      g_mask_q <= '0;
      g_data_q <= '0;
      g_stage_q <= '0;
      g_rx_q <= '0;
      l_mask_q <= '0;
      l_data_q <= '0;
      l_stage_q <= '0;
      l_rx_q <= '0;
      rx_valid_q <= 1'b0;
      rx_drop_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      g_mask_q <= g_mask_d;
      g_data_q <= g_data_d;
      g_stage_q <= g_stage_d;
      g_rx_q <= g_rx_d;
      l_mask_q <= l_mask_d;
      l_data_q <= l_data_d;
      l_stage_q <= l_stage_d;
      l_rx_q <= l_rx_d;
      rx_valid_q <= rx_valid_d;
      rx_drop_q <= rx_drop_d;
      m_valid_q <= m_valid_d;
      m_q <= m_d;
    end
endmodule

// File: tb/tb_etherneco_syncgpio_slave_ex.sv
// tb_etherneco_syncgpio_slave_ex: randomized directed bench with a packet-level reference model
module tb_etherneco_syncgpio_slave_ex;
  localparam int G = 4;
  localparam int LB = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] node_id = 8'd1;
  logic [31:0] gm = '0, gd = '0, lm = '0, ld = '0;
  logic [31:0] global_rx_data, local_rx_data;
  logic rx_valid, rx_drop, rx_start = 1'b0, rx_end = 1'b0, rx_error = 1'b0;
  logic [7:0] rx_type = '0, rx_node = '0;
  logic s_packet_payload = 1'b0, s_packet_fcs = 1'b0, s_packet_crc_en = 1'b0;
  logic s_packet_crc_first = 1'b0, s_packet_first = 1'b0, s_packet_last = 1'b0;
  logic [7:0] s_packet_data = '0;
  logic s_packet_valid = 1'b0, s_packet_ready;
  logic m_packet_payload, m_packet_fcs, m_packet_crc_en, m_packet_crc_first, m_packet_first, m_packet_last;
  logic [7:0] m_packet_data;
  logic m_packet_valid, m_packet_ready = 1'b1;
  int checks = 0, errors = 0;
  bit rand_ready = 0, rand_valid = 0;
  logic [13:0] exp_q[$];
  logic [7:0] pay[$];
  logic [31:0] mdl_g = '0, mdl_l = '0;
  logic [7:0] next_type = 8'h10;
  always #5 clk = ~clk;
  etherneco_syncgpio_slave_ex dut (
    .clk(clk), .reset(reset), .node_id(node_id),
    .global_tx_mask(gm), .global_tx_data(gd), .local_tx_mask(lm), .local_tx_data(ld),
    .global_rx_data(global_rx_data), .local_rx_data(local_rx_data),
    .rx_valid(rx_valid), .rx_drop(rx_drop), .rx_start(rx_start), .rx_end(rx_end),
    .rx_error(rx_error), .rx_type(rx_type), .rx_node(rx_node),
    .s_packet_payload(s_packet_payload), .s_packet_fcs(s_packet_fcs),
    .s_packet_crc_en(s_packet_crc_en), .s_packet_crc_first(s_packet_crc_first),
    .s_packet_first(s_packet_first), .s_packet_last(s_packet_last),
    .s_packet_data(s_packet_data), .s_packet_valid(s_packet_valid), .s_packet_ready(s_packet_ready),
    .m_packet_payload(m_packet_payload), .m_packet_fcs(m_packet_fcs),
    .m_packet_crc_en(m_packet_crc_en), .m_packet_crc_first(m_packet_crc_first),
    .m_packet_first(m_packet_first), .m_packet_last(m_packet_last),
    .m_packet_data(m_packet_data), .m_packet_valid(m_packet_valid), .m_packet_ready(m_packet_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    m_packet_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic [13:0] prev_out;
  bit prev_stall = 0;
  always @(negedge clk) begin
    logic [13:0] cur;
    cur = {m_packet_payload, m_packet_fcs, m_packet_crc_en, m_packet_crc_first,
           m_packet_first, m_packet_last, m_packet_data};
    if (!reset) prev_stall = 0;
    else begin
      if (prev_stall) check("stall_hold", {m_packet_valid, cur}, {1'b1, prev_out});
      if (m_packet_valid && m_packet_ready) begin
        if (exp_q.size() == 0) check("out_pending", exp_q.size(), 1);
        else check("out_byte", cur, exp_q.pop_front());
      end
      prev_stall = m_packet_valid && !m_packet_ready;
      prev_out = cur;
    end
  end

  task automatic put_byte(input logic [5:0] sb, input logic [7:0] d);
    int n = 0;
    bit acc = 0;
    if (rand_valid) while ($urandom_range(0, 2) == 0) step();
    {s_packet_payload, s_packet_fcs, s_packet_crc_en, s_packet_crc_first, s_packet_first, s_packet_last} = sb;
    s_packet_data = d;
    s_packet_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = s_packet_ready;
      step();
      n++;
    end while (!acc && n < 200);
    if (!acc) check("accept_timeout", acc, 1);
    s_packet_valid = 1'b0;
  endtask

  // Sends header(2) + pay[] + FCS(4); abort>=0 asserts reset after that many payload bytes.
  task automatic send_pkt(input logic [7:0] ptype, input bit err, input bit no_start,
                          input bit chain, input bit change_tx, input int abort);
    bit act = ptype == 8'h10;
    int nd = int'(node_id);
    bit le = nd < 16;
    int L = G + nd * LB;
    int n = pay.size();
    logic [31:0] sgm = gm, sgd = gd, slm = lm, sld = ld;
    logic [7:0] b, e;
    bit ok, dr;
    if (!no_start) begin
      rx_start = 1'b1;
      rx_type = ptype;
      step();
      rx_start = 1'b0;
    end
    b = 8'($urandom);
    exp_q.push_back({6'b001110, b});
    put_byte(6'b001110, b);
    b = 8'($urandom);
    exp_q.push_back({6'b001000, b});
    put_byte(6'b001000, b);
    for (int c = 0; c < n; c++) begin
      b = pay[c];
      e = b;
      if (act && c < G) e = (b & ~sgm[8*c+:8]) | (sgd[8*c+:8] & sgm[8*c+:8]);
      else if (act && le && c >= L && c < L + LB)
        e = (b & ~slm[8*(c-L)+:8]) | (sld[8*(c-L)+:8] & slm[8*(c-L)+:8]);
      exp_q.push_back({6'b101000, e});
      put_byte(6'b101000, b);
      if (c == 0 && change_tx) begin
        gm = $urandom; gd = $urandom; lm = $urandom; ld = $urandom;
      end
      if (c + 1 == abort) begin
        #2 reset = 1'b0;
        exp_q.delete();
        mdl_g = '0;
        mdl_l = '0;
        #1;
        check("reset_m", {m_packet_valid, m_packet_payload, m_packet_fcs, m_packet_crc_en,
                          m_packet_crc_first, m_packet_first, m_packet_last, m_packet_data,
                          rx_valid, rx_drop}, 0);
        check("reset_rx", {global_rx_data, local_rx_data}, 0);
        step();
        step();
        reset = 1'b1;
        return;
      end
    end
    for (int c = 0; c < 4; c++) begin
      b = 8'($urandom);
      exp_q.push_back({5'b01000, c == 3, b});
      put_byte({5'b01000, c == 3}, b);
    end
    ok = act && !err && n >= G && (!le || n >= L + LB);
    dr = act && !ok;
    if (ok) begin
      mdl_g = {pay[3], pay[2], pay[1], pay[0]};
      if (le) mdl_l = {pay[L+3], pay[L+2], pay[L+1], pay[L]};
    end
    rx_end = 1'b1;
    rx_error = err;
    if (chain) begin
      rx_start = 1'b1;
      rx_type = next_type;
    end
    step();
    rx_end = 1'b0;
    rx_error = 1'b0;
    rx_start = 1'b0;
    check("rx_valid", rx_valid, ok);
    check("rx_drop", rx_drop, dr);
    check("global_rx", global_rx_data, mdl_g);
    check("local_rx", local_rx_data, mdl_l);
    step();
    check("pulse_width", {rx_valid, rx_drop}, 0);
  endtask

  task automatic fill_pay(input int n, input bit seq);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(seq ? 8'(i) : 8'($urandom));
  endtask

  initial begin
    int n;
    #1 reset = 1'b0;
    step();
    step();
    check("reset_m", {m_packet_valid, m_packet_data, m_packet_payload, m_packet_last, rx_valid, rx_drop}, 0);
    check("reset_rx", {global_rx_data, local_rx_data}, 0);
    check("reset_ready", s_packet_ready, 1);
    reset = 1'b1;
    step();
    node_id = 8'd1;
    gm = 32'hFFFF0000; gd = 32'h12345678; lm = $urandom; ld = $urandom;
    fill_pay(16, 1);
    send_pkt(8'h10, 0, 0, 0, 0, -1);
    check("tp_global", global_rx_data, 32'h03020100);
    check("tp_local", local_rx_data, 32'h0B0A0908);
    fill_pay(16, 0);
    send_pkt(8'h10, 1, 0, 0, 0, -1);
    send_pkt(8'h20, 0, 0, 0, 0, -1);
    fill_pay(20, 0);
    send_pkt(8'h10, 0, 0, 0, 1, -1);
    fill_pay(20, 0);
    send_pkt(8'h10, 0, 0, 0, 0, -1);
    fill_pay(6, 0);
    send_pkt(8'h10, 0, 0, 0, 0, -1);
    node_id = 8'd200;
    fill_pay(8, 0);
    send_pkt(8'h10, 0, 0, 0, 0, -1);
    node_id = 8'd3;
    fill_pay(24, 0);
    next_type = 8'h10;
    send_pkt(8'h10, 0, 0, 1, 0, -1);
    fill_pay(24, 0);
    send_pkt(8'h10, 0, 1, 0, 0, -1);
    rand_ready = 1;
    rand_valid = 1;
    for (int p = 0; p < 14; p++) begin
      node_id = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
      gm = $urandom; gd = $urandom; lm = $urandom; ld = $urandom;
      fill_pay($urandom_range(2, 70), 0);
      send_pkt($urandom_range(0, 3) == 0 ? 8'h20 : 8'h10, $urandom_range(0, 3) == 0, 0, 0,
               $urandom_range(0, 1), -1);
    end
    rand_ready = 0;
    rand_valid = 0;
    node_id = 8'd1;
    fill_pay(16, 0);
    send_pkt(8'h10, 0, 0, 0, 0, 3);
    fill_pay(16, 0);
    send_pkt(8'h10, 0, 0, 0, 0, -1);
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      step();
      n++;
    end
    check("drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
